// File: rtl/spi_pkg.sv
// Shared types and helpers for the 16-bit SPI master.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} spi_mst_state_t;

  localparam int unsigned SPI_WORD_BITS = 16;
  localparam int unsigned SPI_BYTE_BITS = 8;

  // Words travel byte 0 first, so the shift register holds the bytes swapped.
  function automatic logic [SPI_WORD_BITS-1:0] byte_swap16(input logic [SPI_WORD_BITS-1:0] w);
    return {w[SPI_BYTE_BITS-1:0], w[SPI_WORD_BITS-1:SPI_BYTE_BITS]};
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// Half-period counter for sclk; emits rise/fall strobes on the last cycle of each phase.
module spi_sclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase_end,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;  // 0: low half, 1: high half

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= RELOAD;
      phase <= 1'b0;
    end else if (!enable) begin
      cnt   <= RELOAD;
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= RELOAD;
      phase <= ~phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = enable && (cnt == '0);
  assign rise      = phase_end && !phase;
  assign fall      = phase_end && phase;

endmodule

// File: rtl/spi_master_tx.sv
// SPI master (CPOL=0, active-high cs): one 16-bit word per handshake, byte 0 first, MSB first.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_valid,
  input  logic [SPI_WORD_BITS-1:0] tx_data,
  output logic                     tx_ready,
  input  logic                     miso,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs,
  output logic                     busy,
  output logic [SPI_WORD_BITS-1:0] rx_data,
  output logic                     done
);

  localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B = (CS_HOLD > GAP) ? CS_HOLD : GAP;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned DIV_W = $clog2(MAX_C + 1);

  localparam logic [DIV_W-1:0] SETUP_LOAD = DIV_W'(CS_SETUP - 1);
  localparam logic [DIV_W-1:0] HOLD_LOAD  = DIV_W'(CS_HOLD - 1);
  // The IDLE accept cycle is the last cs-low cycle, so GAP state covers one fewer.
  localparam logic [DIV_W-1:0] GAP_LOAD   = DIV_W'(GAP - 2);
  localparam logic [3:0]       LAST_BIT   = 4'(SPI_WORD_BITS - 1);

  spi_mst_state_t            state;
  logic [DIV_W-1:0]          div_cnt;
  logic [SPI_WORD_BITS-1:0]  tx_shift;
  logic [SPI_WORD_BITS-1:0]  rx_shift;
  logic [3:0]                bit_cnt;
  logic                      sclk_en;
  logic                      phase_end;
  logic                      rise;
  logic                      fall;

  assign sclk_en  = (state == LOW) || (state == HIGH);
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE) || tx_valid;

  spi_sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (sclk_en),
    .phase_end(phase_end),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_shift <= byte_swap16(tx_data);
            rx_shift <= '0;
            bit_cnt  <= '0;
            cs       <= 1'b1;
            mosi     <= tx_data[SPI_BYTE_BITS-1];
            div_cnt  <= SETUP_LOAD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            div_cnt <= '0;
            state   <= LOW;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        LOW, HIGH: begin
          if (phase_end) begin
            sclk <= rise;
            if (rise) begin
              state <= HIGH;
            end
            // Falling edge: slave updated miso on the preceding rise.
            if (fall) begin
              rx_shift <= {rx_shift[SPI_WORD_BITS-2:0], miso};
              tx_shift <= {tx_shift[SPI_WORD_BITS-2:0], 1'b0};
              mosi     <= tx_shift[SPI_WORD_BITS-2];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                div_cnt <= HOLD_LOAD;
                state   <= HOLD;
              end else begin
                state <= LOW;
              end
            end
          end
        end
        HOLD: begin
          if (div_cnt == '0) begin
            cs      <= 1'b0;
            done    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= byte_swap16(rx_shift);
            div_cnt <= GAP_LOAD;
            state   <= spi_pkg::GAP;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        spi_pkg::GAP: begin
          if (div_cnt == '0) begin
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
